// File: rtl/roll_sequencer_pkg.sv
// Shared encodings and helpers for the roll sequencer: FSM state codes,
// display range limits and the interval arithmetic.
package roll_sequencer_pkg;

    localparam int VAL_W = 7;
    localparam int IVL_W = 32;
    localparam logic [VAL_W-1:0] MAX_DISPLAY = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_SLOW = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    // Out-of-range bounds (0 or above 99) fall back to the full display range.
    function automatic logic [VAL_W-1:0] eff_bound(input logic [VAL_W-1:0] mx);
        if (mx != '0 && mx <= MAX_DISPLAY) begin
            return mx;
        end
        return MAX_DISPLAY;
    endfunction

    function automatic logic [IVL_W-1:0] dbl_sat(input logic [IVL_W-1:0] x);
        return x[IVL_W-1] ? '1 : {x[IVL_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/roll_sequencer_key_debounce.sv
// Raw pushbutton front end: 2-FF synchronizer, stable-level debounce and a
// single-cycle pulse on each accepted press (debounced 1 -> 0).
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter tracks consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts it.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/roll_sequencer.sv
// Roll/clear control for the random display path: runs the LFSR while rolling,
// rejection-samples the random word and slows the update rate before locking.
module roll_sequencer
    import roll_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int FAST_DIV     = 2500000,
    parameter int ROLL_STEPS   = 20,
    parameter int SLOW_STEPS   = 5,
    parameter int RW           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_roll,
    input  logic             key_clear,
    input  logic [RW-1:0]    rand_in,
    input  logic [VAL_W-1:0] max_val,
    output logic             lfsr_en,
    output logic             upd_stb,
    output logic [VAL_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_o
);

    localparam int STEP_MAX = (ROLL_STEPS > SLOW_STEPS) ? ROLL_STEPS : SLOW_STEPS;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);
    localparam logic [IVL_W-1:0] FAST_IVL = IVL_W'(FAST_DIV);

    state_e             state_q, state_d;
    logic [VAL_W-1:0]   value_q, value_d;
    logic               upd_stb_q, upd_stb_d;
    logic               pending_q, pending_d;
    logic [IVL_W-1:0]   cnt_q, cnt_d;
    logic [IVL_W-1:0]   ivl_q, ivl_d;
    logic [STEP_W-1:0]  step_q, step_d;

    logic               roll_p, clear_p;
    logic [VAL_W-1:0]   cand;
    logic               cand_ok;
    logic               expired;
    logic [IVL_W-1:0]   ivl_dbl;
    logic               unused_rand;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_roll_key (
        .clk     (clk),
        .rst_n   (rst),
        .key_i   (key_roll),
        .press_o (roll_p)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear_key (
        .clk     (clk),
        .rst_n   (rst),
        .key_i   (key_clear),
        .press_o (clear_p)
    );

    assign cand        = rand_in[VAL_W-1:0];
    assign unused_rand = ^rand_in[RW-1:VAL_W];
    assign cand_ok     = (cand != '0) && (cand <= eff_bound(max_val));
    assign expired     = pending_q || (cnt_q == '0);
    assign ivl_dbl     = dbl_sat(ivl_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            value_q   <= '0;
            upd_stb_q <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            ivl_q     <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            upd_stb_q <= upd_stb_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            ivl_q     <= ivl_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        upd_stb_d = 1'b0;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        ivl_d     = ivl_q;
        step_d    = step_q;
        if (clear_p) begin
            state_d   = ST_IDLE;
            value_d   = '0;
            upd_stb_d = 1'b1;
            pending_d = 1'b0;
            cnt_d     = '0;
            step_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (roll_p) begin
                        state_d   = ST_ROLL;
                        cnt_d     = FAST_IVL;
                        ivl_d     = FAST_IVL;
                        step_d    = '0;
                        pending_d = 1'b0;
                    end
                end
                ST_ROLL, ST_SLOW: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    pending_d = expired;
                    // An expired interval waits (pending) until a candidate passes the check.
                    if (expired && cand_ok) begin
                        value_d   = cand;
                        upd_stb_d = 1'b1;
                        pending_d = 1'b0;
                        step_d    = step_q + 1'b1;
                        if (state_q == ST_ROLL) begin
                            if (step_q == STEP_W'(ROLL_STEPS - 1)) begin
                                state_d = ST_SLOW;
                                step_d  = '0;
                                ivl_d   = dbl_sat(FAST_IVL);
                                cnt_d   = dbl_sat(FAST_IVL);
                            end else begin
                                cnt_d = FAST_IVL;
                            end
                        end else begin
                            ivl_d = ivl_dbl;
                            cnt_d = ivl_dbl;
                            if (step_q == STEP_W'(SLOW_STEPS - 1)) begin
                                state_d = ST_HOLD;
                                step_d  = '0;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign lfsr_en = (state_q == ST_ROLL) || (state_q == ST_SLOW);
    assign busy    = lfsr_en;
    assign done    = (state_q == ST_HOLD);
    assign upd_stb = upd_stb_q;
    assign value   = value_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_roll_sequencer.sv
// Directed bench for roll_sequencer with short debounce and roll intervals.
module tb_roll_sequencer;

    localparam int DEB = 4;
    localparam int FD  = 2;
    localparam int RS  = 4;
    localparam int SS  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_roll;
    logic       key_clear;
    logic [7:0] rand_in;
    logic [6:0] max_val;
    logic       lfsr_en;
    logic       upd_stb;
    logic [6:0] value;
    logic       busy;
    logic       done;
    logic [1:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] rnd;
        logic [6:0] mx;
        logic       acc;
    } vec_t;

    vec_t vecs[9];

    roll_sequencer #(
        .DEBOUNCE_CYC (DEB),
        .FAST_DIV     (FD),
        .ROLL_STEPS   (RS),
        .SLOW_STEPS   (SS),
        .RW           (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_roll  (key_roll),
        .key_clear (key_clear),
        .rand_in   (rand_in),
        .max_val   (max_val),
        .lfsr_en   (lfsr_en),
        .upd_stb   (upd_stb),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int c0;
        int roll_entries;
        int hold_off;
        int stb_cnt;
        int state_at_stb;
        logic [1:0] prev_state;
        logic lfsr_at_c0, lfsr_at_hold, done_at_hold;
        logic seen;
        logic [6:0] exp_value;
        int stb_off[$];
        int stb_val[$];
        int exp_off[7];

        exp_off = '{3, 6, 9, 12, 17, 26, 43};
        vecs[0] = '{rnd: 8'd99,  mx: 7'd0,   acc: 1'b1};
        vecs[1] = '{rnd: 8'd100, mx: 7'd0,   acc: 1'b0};
        vecs[2] = '{rnd: 8'd11,  mx: 7'd10,  acc: 1'b0};
        vecs[3] = '{rnd: 8'd10,  mx: 7'd10,  acc: 1'b1};
        vecs[4] = '{rnd: 8'hFF,  mx: 7'd99,  acc: 1'b0};
        vecs[5] = '{rnd: 8'h81,  mx: 7'd1,   acc: 1'b1};
        vecs[6] = '{rnd: 8'd0,   mx: 7'd50,  acc: 1'b0};
        vecs[7] = '{rnd: 8'd105, mx: 7'd127, acc: 1'b0};
        vecs[8] = '{rnd: 8'd50,  mx: 7'd120, acc: 1'b1};

        // Reset
        rst = 1'b0; key_roll = 1'b1; key_clear = 1'b1; rand_in = 8'd0; max_val = 7'd50;
        repeat (3) @(negedge clk);
        check("rst_value", value, 0);
        check("rst_state", state_o, 0);
        check("rst_stb", upd_stb, 0);
        check("rst_lfsr", lfsr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (upd_stb || state_o != 2'd0) seen = 1'b1;
        end
        check("release_quiet", seen, 0);

        // Short glitch on roll key must be ignored
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            key_roll = (i < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (state_o != 2'd0) seen = 1'b1;
        end
        check("short_press_ignored", seen, 0);

        // Full roll: rand 37, bound 50
        rand_in = 8'd37; max_val = 7'd50;
        c0 = -1; roll_entries = 0; hold_off = -1; prev_state = state_o;
        lfsr_at_c0 = 1'b0; lfsr_at_hold = 1'b1; done_at_hold = 1'b0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            key_roll = (cyc < 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (state_o == 2'd1 && prev_state != 2'd1) roll_entries++;
            if (c0 < 0 && state_o == 2'd1) begin
                c0 = cyc;
                lfsr_at_c0 = lfsr_en;
            end
            if (upd_stb && c0 >= 0) begin
                stb_off.push_back(cyc - c0);
                stb_val.push_back(int'(value));
            end
            if (state_o == 2'd3 && hold_off < 0 && c0 >= 0) begin
                hold_off = cyc - c0;
                lfsr_at_hold = lfsr_en;
                done_at_hold = done;
            end
            prev_state = state_o;
        end
        key_roll = 1'b1;
        check("roll_entered", (c0 >= 0), 1);
        check("roll_entries", roll_entries, 1);
        check("lfsr_en_roll", lfsr_at_c0, 1);
        check("stb_count", stb_off.size(), 7);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("stb_off%0d", k), (k < stb_off.size()) ? stb_off[k] : -1, exp_off[k]);
            check($sformatf("stb_val%0d", k), (k < stb_val.size()) ? stb_val[k] : -1, 37);
        end
        check("hold_off", hold_off, 43);
        check("hold_done", done_at_hold, 1);
        check("hold_lfsr", lfsr_at_hold, 0);

        // Rejection: bound 10, word 0x7F rejected until 0x05 appears
        max_val = 7'd10; rand_in = 8'h7F;
        for (int cyc = 0; cyc < 30; cyc++) begin
            key_roll = (cyc < 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (state_o == 2'd1) break;
        end
        key_roll = 1'b1;
        check("hold_to_roll", state_o, 1);
        stb_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (upd_stb) stb_cnt++;
        end
        check("reject_no_stb", stb_cnt, 0);
        rand_in = 8'h05;
        @(negedge clk);
        check("accept5_stb", upd_stb, 1);
        check("accept5_val", value, 5);
        exp_value = 7'd5;
        rand_in = 8'h7F;
        stb_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (upd_stb) stb_cnt++;
        end
        check("accept5_once", stb_cnt, 0);

        // Candidate-check table, applied while the interval is already expired
        for (int v = 0; v < 9; v++) begin
            rand_in = 8'd0;
            repeat (20) @(negedge clk);
            max_val = vecs[v].mx;
            rand_in = vecs[v].rnd;
            @(negedge clk);
            check($sformatf("vec%0d_stb", v), upd_stb, vecs[v].acc);
            if (vecs[v].acc) exp_value = vecs[v].rnd[6:0];
            check($sformatf("vec%0d_val", v), value, exp_value);
            rand_in = 8'd0;
        end
        check("in_slow", state_o, 2);
        check("slow_busy", busy, 1);

        // Clear mid-SLOW
        stb_cnt = 0; state_at_stb = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            key_clear = (cyc < 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (upd_stb) begin
                stb_cnt++;
                state_at_stb = int'(state_o);
            end
        end
        key_clear = 1'b1;
        check("clear_stb_count", stb_cnt, 1);
        check("clear_stb_state", state_at_stb, 0);
        check("clear_state", state_o, 0);
        check("clear_value", value, 0);
        check("clear_busy", busy, 0);
        repeat (10) @(negedge clk);

        // Reach HOLD again, then press both keys together
        rand_in = 8'd37; max_val = 7'd50;
        for (int cyc = 0; cyc < 120; cyc++) begin
            key_roll = (cyc < 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (state_o == 2'd3) break;
        end
        key_roll = 1'b1;
        check("reach_hold", state_o, 3);
        check("hold_value", value, 37);
        repeat (10) @(negedge clk);
        seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            key_roll  = (cyc < 6) ? 1'b0 : 1'b1;
            key_clear = (cyc < 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (state_o == 2'd1) seen = 1'b1;
        end
        key_roll = 1'b1; key_clear = 1'b1;
        check("both_no_roll", seen, 0);
        check("both_state", state_o, 0);
        check("both_value", value, 0);
        repeat (10) @(negedge clk);

        // Asynchronous reset mid-ROLL
        for (int cyc = 0; cyc < 30; cyc++) begin
            key_roll = (cyc < 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (state_o == 2'd1) break;
        end
        key_roll = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_state", state_o, 1);
        check("pre_rst_value", value, 37);
        #2 rst = 1'b0;
        #1;
        check("async_rst_state", state_o, 0);
        check("async_rst_value", value, 0);
        check("async_rst_lfsr", lfsr_en, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_stb", upd_stb, 0);
        @(negedge clk);
        rst = 1'b1;
        stb_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (upd_stb) stb_cnt++;
        end
        check("post_rst_no_stb", stb_cnt, 0);
        check("post_rst_state", state_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/roll_sequencer.md
Name: roll_sequencer

Overview:
Control FSM for the random-number display path. Debounces the roll/clear pushbuttons and free-runs the random source while rolling. Samples the random word, range-limits it and strobes it to the BCD/7-segment stage. The update rate slows over a fixed schedule before the final value locks. Sits between the raw keys, the LFSR and the binary-to-BCD converter.

Parameters:
DEBOUNCE_CYC, 1000000, stable-level cycles required to accept a key change (20 ms at 50 MHz)
FAST_DIV, 2500000, cycles between display updates in ROLL (50 ms)
ROLL_STEPS, 20, number of accepted updates in ROLL
SLOW_STEPS, 5, number of accepted updates in SLOW; the interval doubles after each one
RW, 8, width of the random input word

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-low reset
key_roll  in  1  roll pushbutton, raw, active-low (0 = pressed)
key_clear  in  1  clear pushbutton, raw, active-low
rand_in  in  RW  current random word from the LFSR
max_val  in  7  upper bound of the drawn range, 1..99
lfsr_en  out  1  advance-enable to the LFSR
upd_stb  out  1  one-cycle strobe; value changed this cycle
value  out  7  current drawn value, 0 (cleared) or 1..max
busy  out  1  high in ROLL and SLOW
done  out  1  high in HOLD
state_o  out  2  IDLE=0, ROLL=1, SLOW=2, HOLD=3

Behaviour:
- Reset (rst=0, async): state IDLE; value=0; upd_stb=0; lfsr_en=0; busy=0; done=0; all counters 0; debouncers hold the released level (1).
- Keys: each key passes a 2-FF synchronizer, then the debouncer. The debounced level changes only after DEBOUNCE_CYC consecutive equal synchronized samples. A press pulse fires one cycle on a debounced 1->0 transition. A held key produces exactly one pulse.
- Effective bound: eff_max = max_val if 1..99, else 99.
- Candidate: cand = rand_in[6:0]. It is valid iff 1 <= cand <= eff_max. No modulo (rejection sampling).
- lfsr_en = 1 in ROLL and SLOW, else 0. The LFSR advances every cycle while rolling.
- IDLE: roll press -> ROLL. The interval counter loads FAST_DIV and the step counter clears.
- ROLL: interval counter counts down each cycle. At 0 a pending flag sets.
  - While pending and cand is valid: value<=cand, upd_stb=1, pending clears, step++, counter reloads FAST_DIV.
  - After ROLL_STEPS accepted updates -> SLOW, interval = 2*FAST_DIV.
- SLOW: same accept rule. The interval doubles after each accepted update (internal interval register is 32 bit, saturating). After SLOW_STEPS accepts -> HOLD.
- HOLD: value frozen, done=1. A roll press -> ROLL with the same reload as from IDLE.
- Clear press, any state: -> IDLE, value<=0, upd_stb=1 for one cycle, pending cleared.
- Roll and clear pulses in the same cycle: clear wins.
- Roll press during ROLL/SLOW: ignored; no restart.
- Latency: update strobe in the same cycle the valid cand is seen. value registered, visible next cycle together with upd_stb high.
- max_val changed mid-roll: takes effect at the next candidate check. The already-latched value is not re-checked.
- Reset asserted mid-roll: immediate IDLE, outputs to reset values. No strobe on release.

Decomposition:
- Shared package/header: state encodings (ST_IDLE, ST_ROLL, ST_SLOW, ST_HOLD), MAX_DISPLAY=99, value width 7.
- One sub-module: key_debounce (synchronizer + debounce counter + press pulse, parameter DEBOUNCE_CYC), instanced for key_roll and key_clear.
- FSM, interval/step counters and candidate check stay in roll_sequencer.

Test Plan:
- Bench parameters: DEBOUNCE_CYC=4, FAST_DIV=2, ROLL_STEPS=4, SLOW_STEPS=3, rand_in driven by bench.
- Reset: rst=0 with keys at 1 -> value=0, state_o=0, all outputs 0. Release rst -> no strobe.
- Debounce: key_roll low for 3 cycles, then high -> stays IDLE. Low for 6 cycles -> exactly one transition to ROLL, lfsr_en=1.
- Full roll, rand_in=37, max_val=50:
  - 4 updates spaced 3 cycles apart, value=37 each.
  - 3 SLOW updates with intervals 4, 8, 16 (+1 reload cycle each).
  - Then state_o=3, done=1, lfsr_en=0.
- Rejection: max_val=10, rand_in=0x7F for 20 cycles, then 0x05 -> no upd_stb until 0x05; then value=5, upd_stb=1 exactly once.
- Clamp and clear:
  - max_val=0, rand_in=99 -> accepted, value=99. rand_in=100 -> rejected.
  - key_clear press mid-SLOW -> IDLE, value=0, one upd_stb.
- Simultaneous keys: roll and clear pressed in the same cycle from HOLD -> IDLE, value=0. Async reset mid-ROLL -> IDLE within 0 clock edges.
